adc_ddr_sample_packer: RTL and testbench

// - Sits after the per-lane IDDR capture of an AD9434-style DDR ADC (LANES data pairs, 2 bits per lane per clk).
// - Reassembles 2*LANES-bit samples and trains half-word alignment against a fixed ADC test pattern.
// - Packs SAMPLES_PER_WORD samples plus overrange flags into wide words.
// - Buffers the words in a FWFT FIFO with valid/ready output; everything runs in the ADC clock domain.

---
 rtl/adc_ddr_sample_packer.sv | 236 +++++++++++++++++++++++
 tb/tb_adc_ddr_sample_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ddr_sample_packer.sv
// adc_ddr_sample_packer: DDR ADC lane reassembly, pattern training, sample
// packing and FWFT output FIFO. Optional test ramp: ADC_PACK_TEST_RAMP_EN.
module adc_ddr_sample_packer #(
  parameter int LANES = 6,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH = 16,
  parameter logic [2*LANES-1:0] TRAIN_PATTERN = 12'hA5C,
  parameter int TRAIN_LOCK_CNT = 16,
  parameter int TRAIN_TIMEOUT = 256
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic [LANES-1:0] ddr_q1,
  input  logic [LANES-1:0] ddr_q2,
  input  logic or_in,
  input  logic align_start,
`ifdef ADC_PACK_TEST_RAMP_EN
  input  logic ramp_sel,
`endif
  output logic aligned,
  output logic align_fail,
  output logic [2*LANES*SAMPLES_PER_WORD-1:0] m_data,
  output logic [SAMPLES_PER_WORD-1:0] m_or,
  output logic m_valid,
  input  logic m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0] overflow_cnt
);

  localparam int SW  = 2*LANES;
  localparam int SPW = SAMPLES_PER_WORD;
  localparam int DW  = SW*SPW;
  localparam int FW  = DW+SPW;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int MW  = $clog2(TRAIN_LOCK_CNT+1);
  localparam int TW  = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAIN,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t r_state, w_state_nxt;
  logic r_swap, w_swap_nxt;
  logic [MW-1:0] r_match, w_match_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic r_aligned, r_align_fail;

  logic [LANES-1:0] r_q2_d;
  logic [SW-1:0] r_sample, w_sample;
  logic r_sample_or, w_sample_or;
  logic r_smp_vld;
  logic w_hit;

  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_word;
  logic [SPW-1:0] r_word_or;
  logic r_word_vld;

  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic [15:0] r_ovf;
  logic w_full, w_push, w_drop, w_pop;
  logic [FW-1:0] w_rd_data;

`ifdef ADC_PACK_TEST_RAMP_EN
  logic [SW-1:0] r_ramp;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp <= '0;
    end else if (r_state != S_LOCKED || align_start) begin
      r_ramp <= '0;
    end else begin
      r_ramp <= r_ramp + 1'b1;
    end
  end
`endif

  // swap=1 takes the low half from the previous falling edge
  always_comb begin
    w_sample = r_swap ? {ddr_q1, r_q2_d} : {ddr_q2, ddr_q1};
    w_sample_or = or_in;
`ifdef ADC_PACK_TEST_RAMP_EN
    if (ramp_sel && r_state == S_LOCKED) begin
      w_sample = r_ramp;
      w_sample_or = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_q2_d <= '0;
      r_sample <= '0;
      r_sample_or <= 1'b0;
      r_smp_vld <= 1'b0;
    end else begin
      r_q2_d <= ddr_q2;
      r_sample <= w_sample;
      r_sample_or <= w_sample_or;
      r_smp_vld <= r_aligned && !align_start;
    end
  end

  assign w_hit = (r_sample == TRAIN_PATTERN);

  always_comb begin
    w_state_nxt = r_state;
    w_swap_nxt = r_swap;
    w_match_nxt = r_match;
    w_tmo_nxt = r_tmo;
    if (align_start) begin
      w_state_nxt = S_TRAIN;
      w_swap_nxt = 1'b0;
      w_match_nxt = '0;
      w_tmo_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_TRAIN: begin
          w_match_nxt = w_hit ? r_match + 1'b1 : '0;
          w_tmo_nxt = r_tmo + 1'b1;
          if (r_match == MW'(TRAIN_LOCK_CNT)) begin
            w_state_nxt = S_LOCKED;
          end else if (r_tmo == TW'(TRAIN_TIMEOUT-1)) begin
            w_match_nxt = '0;
            w_tmo_nxt = '0;
            if (!r_swap) begin
              w_swap_nxt = 1'b1;
            end else begin
              w_swap_nxt = 1'b0;
              w_state_nxt = S_FAIL;
            end
          end
        end
        S_LOCKED: ;
        S_FAIL: w_swap_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_swap <= 1'b0;
      r_match <= '0;
      r_tmo <= '0;
      r_aligned <= 1'b0;
      r_align_fail <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_swap <= w_swap_nxt;
      r_match <= w_match_nxt;
      r_tmo <= w_tmo_nxt;
      r_aligned <= (r_state == S_LOCKED) && !align_start;
      r_align_fail <= (r_state == S_FAIL) && !align_start;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_word <= '0;
      r_word_or <= '0;
      r_word_vld <= 1'b0;
    end else if (align_start) begin
      r_idx <= '0;
      r_word <= '0;
      r_word_or <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (r_smp_vld) begin
        r_word[r_idx*SW +: SW] <= r_sample;
        r_word_or[r_idx] <= r_sample_or;
        if (r_idx == IW'(SPW-1)) begin
          r_idx <= '0;
          r_word_vld <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // full is taken from the pre-pop count, so a pop never rescues a push
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_push = r_word_vld && !w_full && !align_start;
  assign w_drop = r_word_vld && w_full && !align_start;
  assign w_pop = m_valid && m_ready && !align_start;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr] <= {r_word_or, r_word};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (align_start) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10: r_cnt <= r_cnt + 1'b1;
        2'b01: r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_drop && r_ovf != 16'hFFFF) begin
        r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  assign w_rd_data = r_mem[r_rd];
  assign m_valid = (r_cnt != '0);
  assign m_data = m_valid ? w_rd_data[DW-1:0] : '0;
  assign m_or = m_valid ? w_rd_data[FW-1:DW] : '0;
  assign fifo_level = r_cnt;
  assign overflow_cnt = r_ovf;
  assign aligned = r_aligned;
  assign align_fail = r_align_fail;

endmodule

// File: tb/tb_adc_ddr_sample_packer.sv
// tb_adc_ddr_sample_packer: directed sequence with a queue scoreboard
// tracking FIFO contents, drops and packing of the DDR sample packer.
module tb_adc_ddr_sample_packer;

  localparam int SW = 12;
  localparam int SPW = 4;
  localparam int DW = 48;
  localparam int FW = 52;
  localparam int DEPTH = 16;

  logic clk_in = 1'b0;
  logic rst_n;
  logic [5:0] ddr_q1, ddr_q2;
  logic or_in, align_start, m_ready;
  logic aligned, align_fail, m_valid;
  logic [DW-1:0] m_data;
  logic [SPW-1:0] m_or;
  logic [4:0] fifo_level;
  logic [15:0] overflow_cnt;
`ifdef ADC_PACK_TEST_RAMP_EN
  logic ramp_sel = 1'b0;
`endif

  adc_ddr_sample_packer dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .ddr_q1(ddr_q1),
    .ddr_q2(ddr_q2),
    .or_in(or_in),
    .align_start(align_start),
`ifdef ADC_PACK_TEST_RAMP_EN
    .ramp_sel(ramp_sel),
`endif
    .aligned(aligned),
    .align_fail(align_fail),
    .m_data(m_data),
    .m_or(m_or),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  logic [FW-1:0] q[$];
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [FW-1:0] pw0, pw1, mword;
  logic model_on = 1'b0;
  int midx = 0;
  int exp_ovf = 0;
  logic [11:0] cur_s;
  logic cur_or;
  logic [11:0] pat = 12'hA5C;
  logic [11:0] sval = 12'h100;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_s(input logic [11:0] s, input logic o);
    cur_s = s;
    cur_or = o;
    ddr_q1 = s[5:0];
    ddr_q2 = s[11:6];
    or_in = o;
  endtask

  // model step for the coming edge, then advance one clock
  task automatic tick();
    logic full_b;
    if (align_start) begin
      q.delete();
      pv0 = 1'b0;
      pv1 = 1'b0;
      model_on = 1'b0;
      midx = 0;
    end else begin
      full_b = (q.size() == DEPTH);
      if (m_valid && m_ready) begin
        chk("pop_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("pop_word", {m_or, m_data}, q[0]);
          void'(q.pop_front());
        end
      end
      if (pv1) begin
        if (full_b) exp_ovf++;
        else q.push_back(pw1);
      end
      pv1 = pv0;
      pw1 = pw0;
      pv0 = 1'b0;
      if (model_on) begin
        mword[midx*SW +: SW] = cur_s;
        mword[DW+midx] = cur_or;
        if (midx == SPW-1) begin
          pv0 = 1'b1;
          pw0 = mword;
          midx = 0;
        end else begin
          midx++;
        end
      end
    end
    @(posedge clk_in);
    #1;
    chk("level", fifo_level, q.size());
    chk("ovf", overflow_cnt, exp_ovf);
    chk("valid", m_valid, q.size() != 0);
  endtask

  task automatic data_steps(input int n);
    for (int i = 0; i < n; i++) begin
      set_s(sval, sval[0] ^ sval[2]);
      sval++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    align_start = 1'b0;
    m_ready = 1'b0;
    set_s(12'h000, 1'b0);
    #23;
    chk("rst_aligned", aligned, 0);
    chk("rst_fail", align_fail, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_or", m_or, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;

    set_s(pat, 1'b0);
    repeat (30) tick();
    chk("idle_inert", aligned, 0);

    // T1 lock
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    repeat (17) tick();
    chk("t1_not_yet", aligned, 0);
    tick();
    chk("t1_aligned", aligned, 1);
    chk("t1_no_fail", align_fail, 0);
    model_on = 1'b1;
    midx = 0;

    // T4 pack
    set_s(12'h001, 1'b0); tick();
    set_s(12'h002, 1'b0); tick();
    set_s(12'h003, 1'b1); tick();
    set_s(12'h004, 1'b0); tick();
    chk("t4_valid_e0", m_valid, 0);
    tick();
    chk("t4_valid_e1", m_valid, 0);
    tick();
    chk("t4_valid_e2", m_valid, 1);
    chk("t4_data", m_data, 48'h004003002001);
    chk("t4_or", m_or, 4'b0100);
    repeat (3) tick();
    chk("t4_hold", m_data, 48'h004003002001);
    m_ready = 1'b1;
    data_steps(24);

    // T2 swapped framing
    ddr_q1 = pat[11:6];
    ddr_q2 = pat[5:0];
    or_in = 1'b0;
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    cyc = 0;
    while (!aligned && cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 256) chk("t2_pre_swap", aligned, 0);
    end
    chk("t2_lock_window", (cyc > 256 && cyc < 276), 1);
    chk("t2_no_fail", align_fail, 0);

    // T3 fail
    set_s(12'h000, 1'b0);
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    chk("t3_aligned_clr", aligned, 0);
    cyc = 0;
    while (!align_fail && cyc < 600) begin
      tick();
      cyc++;
    end
    chk("t3_fail_window", (cyc >= 505 && cyc <= 520), 1);
    chk("t3_fail", align_fail, 1);
    chk("t3_not_aligned", aligned, 0);

    // T5 overflow
    m_ready = 1'b0;
    set_s(pat, 1'b0);
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    chk("t5_fail_clr", align_fail, 0);
    cyc = 0;
    while (!aligned && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t5_lock", aligned, 1);
    model_on = 1'b1;
    midx = 0;
    data_steps(80);
    repeat (2) tick();
    chk("t5_level", fifo_level, 16);
    chk("t5_ovf", overflow_cnt, 4);
    m_ready = 1'b1;
    data_steps(16);

    // T6 restart mid-word with FIFO half full
    m_ready = 1'b0;
    cyc = 0;
    while (!(q.size() >= 8 && midx == 2) && cyc < 200) begin
      data_steps(1);
      cyc++;
    end
    chk("t6_half_full", fifo_level >= 8, 1);
    set_s(pat, 1'b0);
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    chk("t6_level", fifo_level, 0);
    chk("t6_valid", m_valid, 0);
    chk("t6_aligned", aligned, 0);
    chk("t6_ovf_kept", overflow_cnt, 4);
    cyc = 0;
    while (!aligned && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t6_relock", aligned, 1);
    model_on = 1'b1;
    midx = 0;
    set_s(12'h111, 1'b0); tick();
    set_s(12'h222, 1'b1); tick();
    set_s(12'h333, 1'b0); tick();
    set_s(12'h444, 1'b0); tick();
    repeat (2) tick();
    chk("t6_first_valid", m_valid, 1);
    chk("t6_first_data", m_data, 48'h444333222111);
    chk("t6_first_or", m_or, 4'b0010);
    m_ready = 1'b1;
    data_steps(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
